rsa_mont_exp: RTL
=================

RSA_MONT_EXP -- requirements
Module: rsa_mont_exp

Interface
REQ-001 Parameter: WIDTH, 256, operand width in bits and iteration count of both the exponent loop and the Montgomery loop.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_start  input  1  single-cycle request; accepted only in IDLE.
REQ-005 i_t  input  WIDTH  y*2^WIDTH mod N, the pre-transformed base produced by the upstream modulo-product stage.
REQ-006 i_d  input  WIDTH  exponent d.
REQ-007 i_n  input  WIDTH  modulus N; odd, i_t < N.
REQ-008 o_a_pow_d  output  WIDTH  result y^d mod N.
REQ-009 o_finished  output  1  one-cycle completion pulse.
REQ-010 o_busy  output  1  high in every state except IDLE.

Function
REQ-011 The block SHALL use a four-state FSM: IDLE, MONT, CORR, DONE.
REQ-012 IDLE->MONT on an edge with i_start=1; that edge SHALL latch i_t, i_d, i_n, set m=1 and t=i_t, and clear the exponent index i and the bit counter j.
REQ-013 i_start SHALL be ignored in MONT, CORR and DONE; latched operands SHALL NOT change until the next accepted start.
REQ-014 MONT SHALL run two bit-serial Montgomery products in parallel, one bit j per cycle: P1=Mont(m,t) and P2=Mont(t,t).
REQ-015 The per-cycle Montgomery step SHALL be: if a[j], acc+=b; if acc odd, acc+=N; then acc>>=1.
REQ-016 Each accumulator SHALL be WIDTH+2 bits wide, giving no overflow under the invariant acc<2N.
REQ-017 After WIDTH MONT cycles (j=WIDTH-1), the FSM SHALL go to CORR.
REQ-018 CORR SHALL last 1 cycle; in it each accumulator SHALL have N subtracted if it is >=N.
REQ-019 In CORR, t SHALL be replaced by corrected P2; m SHALL be replaced by corrected P1 only if d[i]=1; j SHALL clear and i SHALL increment.
REQ-020 CORR->MONT if i<WIDTH-1, else CORR->DONE.
REQ-021 Latency SHALL be fixed and independent of d: the state SHALL become DONE exactly WIDTH*(WIDTH+1) rising edges after the start-accepting edge.
REQ-022 On entry to DONE, o_a_pow_d SHALL load m[WIDTH-1:0] and o_finished SHALL be 1 for exactly that one cycle.
REQ-023 DONE->IDLE unconditionally after one cycle.
REQ-024 o_a_pow_d SHALL hold its value through IDLE until the next DONE.
REQ-025 d=0 SHALL yield 1 (for N>1).
REQ-026 If i_start=1 on the DONE cycle it SHALL be dropped; a start is accepted only on a later IDLE cycle.
REQ-027 With even N or i_t>=N the result is undefined, but the FSM SHALL still reach DONE at the REQ-021 latency.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, o_a_pow_d=0, o_finished=0, o_busy=0, and clear m, t, i, j and the accumulators.
REQ-029 Reset asserted mid-operation SHALL abort the run with no o_finished pulse; the first start after release SHALL behave as from power-up.

Verification
REQ-030 WIDTH=8, N=187, i_t=158 (y=5), d=3 -> o_finished on edge 72 after start; o_a_pow_d=125; o_busy high for edges 0..72.
REQ-031 WIDTH=8, N=187, i_t=158, d=7 -> o_a_pow_d=146; d=0 -> o_a_pow_d=1; both at latency 72.
REQ-032 WIDTH=256, N=2^256-189, i_t=378 (y=2), d=256 -> o_a_pow_d=189 at latency 65792 edges.
REQ-033 WIDTH=8, during a d=3 run, pulse i_start at edge 20 with d=7, i_t=1 -> ignored; result 125 at edge 72; a single o_finished pulse.
REQ-034 WIDTH=8, assert rst_n low at edge 30 of a d=7 run -> outputs 0 and no pulse; after release, start with d=3 -> 125 at latency 72.
REQ-035 WIDTH=8, i_start held high continuously -> back-to-back runs; each o_finished is followed by exactly one IDLE cycle before the next start is accepted; o_a_pow_d is stable between pulses.

Source files
------------

// File: rtl/rsa_mont_exp.sv
// Modular exponentiation y^d mod N by right-to-left square-and-multiply.
// Both products are bit-serial Montgomery products that run in parallel.
module rsa_mont_exp #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_t,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_a_pow_d,
    output logic             o_finished,
    output logic             o_busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, MONT, CORR, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] t_q, d_q, n_q, m_q, res_q;
    logic [AW-1:0]    acc1_q, acc2_q;
    logic [IW-1:0]    i_q, j_q;
    logic [WIDTH-1:0] p1_corr, p2_corr;
    logic             last_j, last_i;

    // One Montgomery step: add b when the multiplier bit is set, make the sum
    // even by adding N, then halve. Holds acc < 2N for a, b < N.
    function automatic logic [AW-1:0] mont_step(input logic [AW-1:0]    acc,
                                                input logic             a_bit,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] n);
        logic [AW-1:0] s;
        s = acc + (a_bit ? {2'b00, b} : '0);
        if (s[0]) s = s + {2'b00, n};
        return s >> 1;
    endfunction

    function automatic logic [WIDTH-1:0] reduce(input logic [AW-1:0]    acc,
                                                input logic [WIDTH-1:0] n);
        logic [AW-1:0] r;
        r = (acc >= {2'b00, n}) ? acc - {2'b00, n} : acc;
        return r[WIDTH-1:0];
    endfunction

    assign p1_corr = reduce(acc1_q, n_q);
    assign p2_corr = reduce(acc2_q, n_q);
    assign last_j  = (j_q == IW'(WIDTH - 1));
    assign last_i  = (i_q == IW'(WIDTH - 1));

    // NOTE: every output of this block is given a default first, so no path
    // leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = MONT;
            MONT:    if (last_j) state_d = CORR;
            CORR:    state_d = last_i ? DONE : MONT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            d_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            res_q   <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        t_q    <= i_t;
                        d_q    <= i_d;
                        n_q    <= i_n;
                        m_q    <= WIDTH'(1);
                        i_q    <= '0;
                        j_q    <= '0;
                        acc1_q <= '0;
                        acc2_q <= '0;
                    end
                end
                MONT: begin
                    acc1_q <= mont_step(acc1_q, m_q[j_q], t_q, n_q);
                    acc2_q <= mont_step(acc2_q, t_q[j_q], t_q, n_q);
                    j_q    <= j_q + 1'b1;
                end
                CORR: begin
                    t_q    <= p2_corr;
                    if (d_q[i_q]) m_q <= p1_corr;
                    // The result register captures the final m on the edge into DONE.
                    if (last_i) res_q <= d_q[i_q] ? p1_corr : m_q;
                    acc1_q <= '0;
                    acc2_q <= '0;
                    j_q    <= '0;
                    i_q    <= i_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_a_pow_d  = res_q;
    assign o_finished = (state_q == DONE);
    assign o_busy     = (state_q != IDLE);

endmodule
